// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and helpers for the multi-channel debouncer.
//   deb_state_t  per-channel filter state
//   cnt_width()  width of a stability counter that must hold 0..stable
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } deb_state_t;

  function automatic int cnt_width(input int stable);
    return $clog2(stable + 1);
  endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// debounce_multi_if: signal bundle between board-level inputs and the
// debouncer.
//   sample_en   qualifying-sample strobe (tie high for per-clock sampling)
//   din         raw asynchronous inputs, one bit per channel
//   level_out   debounced level per channel
//   rise_pulse  one-cycle pulse on a 0->1 change of level_out
//   fall_pulse  one-cycle pulse on a 1->0 change of level_out
//   any_event   OR of all rise and fall pulses, same cycle as the pulses
// master: the side that supplies inputs and consumes results.
// slave:  the debouncer itself.
interface debounce_multi_if #(
  parameter int N = 2
);
  logic         sample_en;
  logic [N-1:0] din;
  logic [N-1:0] level_out;
  logic [N-1:0] rise_pulse;
  logic [N-1:0] fall_pulse;
  logic         any_event;

  modport master (
    output sample_en, din,
    input  level_out, rise_pulse, fall_pulse, any_event
  );

  modport slave (
    input  sample_en, din,
    output level_out, rise_pulse, fall_pulse, any_event
  );
endinterface

// File: rtl/debounce_chan.sv
// debounce_chan: one debouncer channel.
//   clk, reset     system clock, synchronous active-high reset
//   sample_en      qualifying-sample strobe
//   din            raw asynchronous input
//   level_out      debounced level (pure function of state)
//   rise_pulse     registered one-cycle pulse on level 0->1
//   fall_pulse     registered one-cycle pulse on level 1->0
//   rise_next      combinational value rise_pulse takes at the next edge
//   fall_next      combinational value fall_pulse takes at the next edge
// The *_next outputs let the parent register its any_event flag on the
// same edge as the pulses instead of one cycle later.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic din,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic rise_next,
  output logic fall_next
);

  localparam int              CNT_W   = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(STABLE_CYCLES);
  localparam deb_state_t      RST_ST  = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  logic             s1, s2;
  deb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;

  // Synchroniser runs every clock; sample_en only gates the counter.
  // NOTE: registers are updated with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours (s2 sees the old s1).
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= RESET_LEVEL;
      s2 <= RESET_LEVEL;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // Saturating increment: the counter never wraps back to zero.
  assign cnt_inc = (cnt == CNT_TOP) ? cnt : cnt + 1'b1;

  // NOTE: every output of this block is given a default before the case,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_next = 1'b0;
    fall_next = 1'b0;
    unique case (state)
      STABLE_LO: begin
        if (s2) begin
          state_nxt = WAIT_HI;
          cnt_nxt   = '0;
        end
      end
      WAIT_HI: begin
        if (!s2) begin
          // Any reversal drops back at once, strobe or not.
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end else if (sample_en) begin
          if (cnt_inc == CNT_TOP) begin
            state_nxt = STABLE_HI;
            cnt_nxt   = '0;
            rise_next = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      STABLE_HI: begin
        if (!s2) begin
          state_nxt = WAIT_LO;
          cnt_nxt   = '0;
        end
      end
      WAIT_LO: begin
        if (s2) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
        end else if (sample_en) begin
          if (cnt_inc == CNT_TOP) begin
            state_nxt = STABLE_LO;
            cnt_nxt   = '0;
            fall_next = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      default: begin
        state_nxt = RST_ST;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RST_ST;
      cnt        <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rise_pulse <= rise_next;
      fall_pulse <= fall_next;
    end
  end

  assign level_out = (state == STABLE_HI) || (state == WAIT_LO);

endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: N independent debouncer channels behind one interface.
//   clk    system clock, all state updates on the rising edge
//   reset  synchronous active-high reset
//   bus    debounce_multi_if slave: sample_en, din in; level_out,
//          rise_pulse, fall_pulse, any_event out
// Parameters: N channels, STABLE_CYCLES qualifying samples (>= 1) to
// accept a new level, RESET_LEVEL for outputs and synchronisers in reset.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N             = 2,
  parameter int STABLE_CYCLES = 4,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input logic             clk,
  input logic             reset,
  debounce_multi_if.slave bus
);

  logic [N-1:0] level, rise, fall, rise_next, fall_next;
  logic         any_event_q;

  for (genvar i = 0; i < N; i++) begin : g_chan
    debounce_chan #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_LEVEL   (RESET_LEVEL)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .sample_en  (bus.sample_en),
      .din        (bus.din[i]),
      .level_out  (level[i]),
      .rise_pulse (rise[i]),
      .fall_pulse (fall[i]),
      .rise_next  (rise_next[i]),
      .fall_next  (fall_next[i])
    );
  end

  // Registered from the channels' next-pulse values so any_event lines up
  // with the pulses themselves.
  always_ff @(posedge clk) begin
    if (reset) any_event_q <= 1'b0;
    else       any_event_q <= |(rise_next | fall_next);
  end

  assign bus.level_out  = level;
  assign bus.rise_pulse = rise;
  assign bus.fall_pulse = fall;
  assign bus.any_event  = any_event_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Testbench for debounce_multi: two instances (RESET_LEVEL 0 and 1).
// Expected pulse events are queued at stimulus time; a monitor pops one
// whenever a DUT shows a pulse or any_event and compares every field,
// including the cycle it appears in.
module tb_debounce_multi;

  localparam int SC = 4;

  typedef struct packed {
    int         cyc;
    logic [1:0] rise;
    logic [1:0] fall;
    logic       any;
    logic [1:0] level;
  } ev_t;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   gated = 1'b0;
  ev_t  q0[$];
  ev_t  q1[$];

  debounce_multi_if #(.N(2)) if0 ();
  debounce_multi_if #(.N(2)) if1 ();

  debounce_multi #(.N(2), .STABLE_CYCLES(SC), .RESET_LEVEL(1'b0)) u_dut0 (
    .clk (clk), .reset (rst0), .bus (if0.slave)
  );
  debounce_multi #(.N(2), .STABLE_CYCLES(SC), .RESET_LEVEL(1'b1)) u_dut1 (
    .clk (clk), .reset (rst1), .bus (if1.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic score(input string name, input bit have, input ev_t exp,
                       input ev_t act);
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL %s unexpected event: cyc=%0d rise=%b fall=%b any=%b lvl=%b",
               name, act.cyc, act.rise, act.fall, act.any, act.level);
    end else if (act !== exp) begin
      errors++;
      $display("FAIL %s event: got cyc=%0d rise=%b fall=%b any=%b lvl=%b, want cyc=%0d rise=%b fall=%b any=%b lvl=%b",
               name, act.cyc, act.rise, act.fall, act.any, act.level,
               exp.cyc, exp.rise, exp.fall, exp.any, exp.level);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    ev_t act, e;
    if ((if0.rise_pulse | if0.fall_pulse) != 2'b00 || if0.any_event) begin
      act = '{cyc, if0.rise_pulse, if0.fall_pulse, if0.any_event, if0.level_out};
      if (q0.size() > 0) begin e = q0.pop_front(); score("dut0", 1'b1, e, act); end
      else score("dut0", 1'b0, '0, act);
    end
    if ((if1.rise_pulse | if1.fall_pulse) != 2'b00 || if1.any_event) begin
      act = '{cyc, if1.rise_pulse, if1.fall_pulse, if1.any_event, if1.level_out};
      if (q1.size() > 0) begin e = q1.pop_front(); score("dut1", 1'b1, e, act); end
      else score("dut1", 1'b0, '0, act);
    end
  end

  // Expected event at negedge with cycle count c_exp.
  task automatic expect_ev(input int which, input int c_exp, input logic [1:0] r,
                           input logic [1:0] f, input logic [1:0] lvl);
    ev_t e;
    e = '{c_exp, r, f, |(r | f), lvl};
    if (which == 0) q0.push_back(e);
    else            q1.push_back(e);
  endtask

  // Advance to the next falling edge; strobe sample_en on every edge that
  // is a multiple of 5 when gated, otherwise keep it high.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (gated) if0.sample_en = ((cyc + 1) % 5 == 0);
      else       if0.sample_en = 1'b1;
    end
  endtask

  initial begin
    int c;
    rst0 = 1'b1; rst1 = 1'b1;
    if0.din = 2'b00; if0.sample_en = 1'b1;
    if1.din = 2'b11; if1.sample_en = 1'b1;
    tick(3);

    // Reset state, RESET_LEVEL=0
    check("rst0 level", 32'(if0.level_out), 32'h0);
    check("rst0 pulses", 32'({if0.rise_pulse, if0.fall_pulse}), 32'h0);
    check("rst0 any", 32'(if0.any_event), 32'h0);
    rst0 = 1'b0;
    tick(3);

    // Clean rise on channel 0: edge 6 after first sample
    c = cyc; if0.din = 2'b01; expect_ev(0, c + 7, 2'b01, 2'b00, 2'b01);
    tick(10);
    check("ch1 stays low", 32'(if0.level_out), 32'h1);

    // Clean fall on channel 0
    c = cyc; if0.din = 2'b00; expect_ev(0, c + 7, 2'b00, 2'b01, 2'b00);
    tick(10);

    // Bounce: 1 for 3 cycles, 0 for 1, then 1 steady
    if0.din = 2'b01; tick(3);
    if0.din = 2'b00; tick(1);
    c = cyc; if0.din = 2'b01; expect_ev(0, c + 7, 2'b01, 2'b00, 2'b01);
    tick(10);

    // Bring channel 1 high, then drop both together
    c = cyc; if0.din = 2'b11; expect_ev(0, c + 7, 2'b10, 2'b00, 2'b11);
    tick(10);
    check("both high", 32'(if0.level_out), 32'h3);
    c = cyc; if0.din = 2'b00; expect_ev(0, c + 7, 2'b00, 2'b11, 2'b00);
    tick(10);
    check("both low", 32'(if0.level_out), 32'h0);

    // Gated sampling: strobe on edges that are multiples of 5
    gated = 1'b1;
    while (cyc % 5 != 0) tick(1);
    c = cyc; if0.din = 2'b10; expect_ev(0, c + 20, 2'b10, 2'b00, 2'b10);
    tick(25);
    check("gated rise level", 32'(if0.level_out), 32'h2);
    while (cyc % 5 != 0) tick(1);
    c = cyc; if0.din = 2'b00;
    // one count at c+5, glitch restarts the window, WAIT_LO re-entered c+10
    expect_ev(0, c + 30, 2'b00, 2'b10, 2'b00);
    tick(6); if0.din = 2'b10;
    tick(1); if0.din = 2'b00;
    tick(25);
    check("gated fall level", 32'(if0.level_out), 32'h0);
    gated = 1'b0;
    tick(2);

    // RESET_LEVEL=1 instance
    check("rst1 level", 32'(if1.level_out), 32'h3);
    check("rst1 pulses", 32'({if1.rise_pulse, if1.fall_pulse, if1.any_event}), 32'h0);
    tick(1); rst1 = 1'b0; tick(3);
    c = cyc; if1.din = 2'b00; expect_ev(1, c + 7, 2'b00, 2'b11, 2'b00);
    tick(10);
    // Reset in the middle of WAIT_HI: bounce discarded, no pulse
    if1.din = 2'b11; tick(4);
    rst1 = 1'b1; tick(1);
    rst1 = 1'b0;
    check("mid-wait reset level", 32'(if1.level_out), 32'h3);
    check("mid-wait reset pulses", 32'({if1.rise_pulse, if1.fall_pulse, if1.any_event}), 32'h0);
    c = cyc; if1.din = 2'b00; expect_ev(1, c + 7, 2'b00, 2'b11, 2'b00);
    tick(12);

    check("dut0 events left", 32'(q0.size()), 32'h0);
    check("dut1 events left", 32'(q1.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
# debounce_multi

Parametrised multi-channel debouncer; successor to the two-channel single-purpose debouncer that cleans the load and clock-step push-button inputs. Each of N asynchronous inputs is synchronised, filtered by a per-channel stability counter, and presented as a clean level plus one-cycle rise and fall pulses. A shared sample enable lets a prescaler stretch the debounce window to millisecond scale without widening the counters. The block sits between board pins and every control FSM that consumes buttons or switches.

## Interface
- `N`, default 2: number of independent channels.
- `STABLE_CYCLES`, default 4: number of consecutive qualifying samples required to accept a new level, minimum 1.
- `RESET_LEVEL`, default 0: value of every level output and synchroniser stage while `reset` is high.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sample_en`  in  1  qualifying-sample strobe from an external prescaler; tie high for per-clock sampling.
- `din`  in  N  raw asynchronous inputs.
- `level_out`  out  N  debounced level per channel.
- `rise_pulse`  out  N  one-cycle pulse when the channel's `level_out` goes 0→1.
- `fall_pulse`  out  N  one-cycle pulse when the channel's `level_out` goes 1→0.
- `any_event`  out  1  OR of all rise and fall pulses, registered in the same cycle as the pulses.

## Operation
- Per channel: 2-flop synchroniser `s1`, `s2` clocked every cycle, independent of `sample_en`.
- FSM per channel with states STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
  - STABLE_LO: `s2`=1 → WAIT_HI with counter cleared to 0.
  - WAIT_HI: `s2`=0 → STABLE_LO with counter cleared, no pulse. This happens immediately, whether or not `sample_en` is high. `s2`=1 with `sample_en`=1 → counter +1. When the counter reaches `STABLE_CYCLES`, move to STABLE_HI, set `level_out`=1, and assert `rise_pulse` for one cycle.
  - STABLE_HI and WAIT_LO mirror the above with polarity inverted and `fall_pulse`.
- Counter width is `CNT_W` = clog2(`STABLE_CYCLES`+1). The counter saturates and never wraps. It is zero in both STABLE states.
- `level_out` is a pure function of state: 1 in STABLE_HI and WAIT_LO.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulse in the same cycle, and `any_event` is 1 for that cycle.
- Reset state is STABLE_HI if `RESET_LEVEL`=1, else STABLE_LO.
  - `s1`, `s2` are loaded with `RESET_LEVEL` and counters are cleared.
  - All pulses and `any_event` are 0.
  - A bounce in progress when reset is asserted is discarded, with no pulse emitted.

## Timing
- Reset values: `level_out`={N{`RESET_LEVEL`}}; `rise_pulse`, `fall_pulse`=0; `any_event`=0.
- With `sample_en` held high, a clean change on `din` sampled at edge E0:
  - reaches `s2` at E1.
  - enters WAIT at E2.
  - moves `level_out` at E2+`STABLE_CYCLES`. With default parameters that is edge 6 after the first sample.
- The pulse is high for exactly the cycle following the edge that updates `level_out`.
- With `sample_en` gated, latency is 2 + `STABLE_CYCLES` qualifying strobes plus the clocks in between.
- A reversal of even one cycle during WAIT restarts the full window.
- `STABLE_CYCLES`=1: acceptance happens on the first enabled sample in WAIT.

## Structure
- Package `debounce_pkg` holds:
  - the state enum `deb_state_t` (STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO).
  - the function `cnt_width(stable)` that returns clog2(stable+1).
- Sub-module `debounce_chan` holds one channel (synchroniser, FSM, counter, pulses). The top generates N instances and ORs the pulses into the register for `any_event`.

## Test plan
- Reset with `RESET_LEVEL`=0, then `din`=2'b01 held clean with `sample_en`=1 → `level_out[0]` rises at edge 6 after the first sample, `rise_pulse[0]` is high for 1 cycle, `any_event`=1 in that same cycle, and channel 1 stays 0.
- Bounce on channel 0 (1 for 3 cycles, 0 for 1, then 1 steady) with `STABLE_CYCLES`=4 → no pulse during the bounce, and `level_out` rises 6 edges after the final 0→1.
- Both channels toggle 1→0 on the same cycle after both are stable high → `fall_pulse`=2'b11 for one cycle and `any_event`=1 for one cycle.
- `sample_en` pulsing 1 in 5 cycles, `din[1]` 0→1 held → acceptance after 4 strobes following WAIT entry. A 1-cycle glitch back to 0 between strobes restarts the count.
- Reset asserted mid-WAIT_HI, with `RESET_LEVEL`=1 on a second build → `level_out`=all-1 the cycle after reset and no pulses. Then a held 0 input produces `fall_pulse` after 2+`STABLE_CYCLES` edges.
